// File: rtl/demux_disp_pkg.sv
// Shared definitions for the demux dispatcher: FSM encoding, channel indices
// and the rotating-priority search helper.
package demux_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARB  = 2'b01,
    SEND = 2'b10
  } state_e;

  localparam int NUM_CH = 4;
  localparam int DW     = 2;
  localparam int CH_W   = 0;
  localparam int CH_X   = 1;
  localparam int CH_Y   = 2;
  localparam int CH_Z   = 3;

  // Returns {found, index} of the first ready channel starting at ptr.
  // Walking k downwards lets the smallest offset win.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] rdy);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (rdy[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_dispatcher_demux.sv
// 1-to-4 demultiplexer: A is steered onto the output chosen by SEL, the
// other outputs read zero.
module demux_dispatcher_demux
  import demux_disp_pkg::*;
#(
  parameter int DW_P = DW
) (
  input  logic [DW_P-1:0] A,
  input  logic [1:0]      SEL,
  output logic [DW_P-1:0] W,
  output logic [DW_P-1:0] X,
  output logic [DW_P-1:0] Y,
  output logic [DW_P-1:0] Z
);

  logic [NUM_CH-1:0][DW_P-1:0] lane;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign lane[g] = (SEL == 2'(g)) ? A : '0;
  end

  assign W = lane[CH_W];
  assign X = lane[CH_X];
  assign Y = lane[CH_Y];
  assign Z = lane[CH_Z];

endmodule

// File: rtl/demux_dispatcher.sv
// Round-robin word dispatcher onto four ready/valid channels with ARB timeout.
// Optional DISPATCH_CNT_EN adds a saturating sent_cnt output.
module demux_dispatcher
  import demux_disp_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [3:0]    ch_ready,
  output logic [3:0]    ch_valid,
  output logic [DW-1:0] W,
  output logic [DW-1:0] X,
  output logic [DW-1:0] Y,
  output logic [DW-1:0] Z,
  output logic [1:0]    sel,
  output logic          drop,
  output logic          busy
`ifdef DISPATCH_CNT_EN
  ,
  output logic [7:0]    sent_cnt
`endif
);

  state_e        state_q;
  logic [1:0]    rr_ptr_q;
  logic [1:0]    sel_q;
  logic [7:0]    wait_q;
  logic [DW-1:0] hold_q;
  logic          drop_q;
  logic [2:0]    grant_d;
  logic          hs_d;
  logic [DW-1:0] dmx_a;

  // ch_ready is used live in ARB; nothing about it is remembered.
  assign grant_d = rr_pick(rr_ptr_q, ch_ready);
  assign hs_d    = (state_q == SEND) && ch_ready[sel_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      wait_q   <= '0;
      hold_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        IDLE: if (in_valid) begin
          hold_q  <= in_data;
          wait_q  <= '0;
          state_q <= ARB;
        end
        ARB: if (grant_d[2]) begin
          sel_q   <= grant_d[1:0];
          state_q <= SEND;
        end else if (wait_q + 8'd1 == 8'(MAX_WAIT)) begin
          drop_q  <= 1'b1;
          hold_q  <= '0;
          wait_q  <= '0;
          state_q <= IDLE;
        end else begin
          wait_q <= wait_q + 8'd1;
        end
        SEND: if (hs_d) begin
          rr_ptr_q <= sel_q + 2'd1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_CNT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (hs_d && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end
  assign sent_cnt = cnt_q;
`endif

  assign in_ready = rst_n && (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign ch_valid = (state_q == SEND) ? (4'b0001 << sel_q) : 4'b0000;
  assign sel      = sel_q;
  assign drop     = drop_q;
  assign dmx_a    = (state_q == SEND) ? hold_q : '0;

  demux_dispatcher_demux #(.DW_P(DW)) u_demux (
    .A   (dmx_a),
    .SEL (sel_q),
    .W   (W),
    .X   (X),
    .Y   (Y),
    .Z   (Z)
  );

endmodule
